lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
Shares the single-read/single-write LSU line buffer (registered read, 1-cycle latency) between NUM_RD read requesters and one write requester.
- Reads: round-robin arbitration with valid/ready handshakes.
- Writes: forwarded directly to the LSU write port.
- Hazard: a read to the address being written in the same cycle is stalled so it returns the new data.
- Position: between the LSU and the pixel-stream engines (fetch/fusion stages).

Parameters:
- DATA_WIDTH, 128, beat width (16 pixels x 8 bit).
- ADDR_WIDTH, 14, LSU beat address width.
- NUM_RD, 3, number of read requesters (2..8).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_req_valid  in  NUM_RD  per-requester read request.
- rd_req_addr  in  NUM_RD*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_req_ready  out  NUM_RD  one-hot grant; at most one bit set.
- rd_resp_valid  out  NUM_RD  one-hot; data valid for the requester granted the previous cycle.
- rd_resp_data  out  DATA_WIDTH  broadcast read data.
- wr_valid  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  write accepted.
- lsu_read_enable  out  1  to LSU read_enable.
- lsu_read_ptr  out  ADDR_WIDTH  to LSU read_ptr.
- lsu_read_data  in  DATA_WIDTH  from LSU read_data.
- lsu_write_enable  out  1  to LSU write_enable.
- lsu_write_ptr  out  ADDR_WIDTH  to LSU write_ptr.
- lsu_write_data  out  DATA_WIDTH  to LSU write_data.

Behaviour:
- Reset values: rr_ptr = 0, rd_resp_valid = 0, resp_owner = 0. While rst is high, every ready and enable output is 0.
- Write path (combinational):
  - wr_ready = !rst.
  - lsu_write_enable = wr_valid & wr_ready.
  - lsu_write_ptr / lsu_write_data = wr_addr / wr_data.
- Read grant (combinational):
  - Search requesters starting at rr_ptr, ascending with wrap NUM_RD-1 -> 0; grant the first valid one.
  - Grant g sets rd_req_ready[g], lsu_read_enable = 1, lsu_read_ptr = rd_req_addr[g].
  - A handshake completes when valid & ready are both high in the same cycle.
- Same-address hazard:
  - If lsu_write_enable and the selected address == wr_addr, no read is granted that cycle.
  - rr_ptr is unchanged, so the same requester wins next cycle and reads the freshly written data.
- rr_ptr update: on a grant, rr_ptr <= (g == NUM_RD-1) ? 0 : g+1. Otherwise it holds.
- Response:
  - Registered rd_resp_valid <= one-hot(g) when granted, else 0.
  - rd_resp_data = lsu_read_data (pass-through).
  - Latency is exactly 1 cycle from handshake. There is no response backpressure; requesters must sink data.
- Throughput: one read and one write per cycle. Back-to-back reads from different requesters are allowed.
- Fairness: each continuously-valid requester is granted at least once every NUM_RD cycles, excluding hazard stalls.
- Requester contract: a requester holds valid and addr stable until it sees ready.
- Reset mid-operation: an in-flight response is dropped (rd_resp_valid forced to 0 asynchronously). LSU contents and lsu_read_data are not reset.
- Parameter check: NUM_RD outside 2..8 stops elaboration (generate-time $error).

Optional Feature:
- Macro: LSU_ARB_STATS_EN.
- With the macro defined, extra outputs are present:
  - grant_count, NUM_RD*16 bits: per-requester grant counters, saturating at 16'hFFFF.
  - hazard_count, 16 bits: hazard-stall counter, saturating.
  - All counters reset to 0 and clear synchronously on stats_clr (input, 1 bit).
- Without the macro, these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package lsu_arb_pkg:
  - PIXELS_PER_BEAT = 16.
  - Default DATA_WIDTH / ADDR_WIDTH.
  - STAT_WIDTH = 16.
  - Function onehot_to_idx.
- Sub-module rr_arbiter (NUM_RD): inputs req, rr_ptr, stall; outputs grant one-hot and grant index. lsu_arbiter instantiates it once and owns rr_ptr and the response register.

Test Plan:
- Single reader: rd_req_valid = 3'b001, addr0 = 14'h0010, RAM[0x10] = A5..A5 -> ready[0] in the same cycle; next cycle rd_resp_valid = 3'b001, data = A5..A5.
- All three valid continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles; rd_resp_valid follows one cycle later; no idle cycles.
- Write 0x0020 <= 1122..EF while requester 1 reads 0x0020 in the same cycle -> no grant that cycle; grant to requester 1 next cycle; response returns 1122..EF; (STATS) hazard_count = 1.
- Write 0x0030 with a read to 0x0031 in the same cycle -> both proceed in one cycle; read returns the old contents of 0x0031.
- Grant to requester 2 at cycle N, rst asserted between N and N+1 -> rd_resp_valid = 0 immediately; after release rr_ptr = 0 and requester 0 wins first.
- (STATS) 70000 grants to requester 0, then stats_clr -> grant_count[0] saturates at FFFF, then reads 0 one cycle after the clear.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU line-buffer arbiter.
package lsu_arb_pkg;

  localparam int PIXELS_PER_BEAT = 16;
  localparam int DEF_DATA_WIDTH  = PIXELS_PER_BEAT * 8;
  localparam int DEF_ADDR_WIDTH  = 14;
  localparam int STAT_WIDTH      = 16;
  localparam int MAX_RD          = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_RD-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_RD; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester at or after rr_ptr (with wrap) wins.
// stall only masks the grant; sel_valid/grant_idx still reflect the selection.
module rr_arbiter import lsu_arb_pkg::*; #(
  parameter  int NUM_RD = 3,
  localparam int IDX_W  = $clog2(NUM_RD)
) (
  input  logic [NUM_RD-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  input  logic              stall,
  output logic [NUM_RD-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              sel_valid
);

  logic [NUM_RD-1:0] sel;
  logic              found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_RD]) begin
        sel[(int'(rr_ptr) + k) % NUM_RD] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign sel_valid = found;
  assign grant_idx = IDX_W'(onehot_to_idx(MAX_RD'(sel)));
  assign grant     = stall ? '0 : sel;

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the LSU line buffer between NUM_RD round-robin readers and one writer.
// Optional statistics counters are enabled with `define LSU_ARB_STATS_EN.
module lsu_arbiter import lsu_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_req_valid,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]            rd_req_ready,
  output logic [NUM_RD-1:0]            rd_resp_valid,
  output logic [DATA_WIDTH-1:0]        rd_resp_data,
  input  logic                         wr_valid,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  output logic                         lsu_read_enable,
  output logic [ADDR_WIDTH-1:0]        lsu_read_ptr,
  input  logic [DATA_WIDTH-1:0]        lsu_read_data,
  output logic                         lsu_write_enable,
  output logic [ADDR_WIDTH-1:0]        lsu_write_ptr,
  output logic [DATA_WIDTH-1:0]        lsu_write_data
`ifdef LSU_ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [NUM_RD*STAT_WIDTH-1:0] grant_count,
  output logic [STAT_WIDTH-1:0]        hazard_count
`endif
);

  localparam int IDX_W = $clog2(NUM_RD);

  if (NUM_RD < 2 || NUM_RD > MAX_RD) begin : g_bad_num_rd
    $error("lsu_arbiter: NUM_RD must be in 2..8");
  end

  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_RD-1:0]                 grant;
  logic [IDX_W-1:0]                  grant_idx, rr_ptr, resp_owner;
  logic                              sel_valid, hazard, resp_vld;
  logic [ADDR_WIDTH-1:0]             sel_addr;

  assign addr_v   = rd_req_addr;
  assign sel_addr = addr_v[grant_idx];

  assign wr_ready         = !rst;
  assign lsu_write_enable = wr_valid & wr_ready;
  assign lsu_write_ptr    = wr_addr;
  assign lsu_write_data   = wr_data;

  // Buffer reads old data on a same-cycle collision, so hold the read one cycle.
  assign hazard = lsu_write_enable & sel_valid & (sel_addr == wr_addr);

  rr_arbiter #(.NUM_RD(NUM_RD)) u_rr (
    .req       (rd_req_valid),
    .rr_ptr    (rr_ptr),
    .stall     (hazard | rst),
    .grant     (grant),
    .grant_idx (grant_idx),
    .sel_valid (sel_valid)
  );

  assign rd_req_ready    = grant;
  assign lsu_read_enable = |grant;
  assign lsu_read_ptr    = sel_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      resp_vld   <= 1'b0;
      resp_owner <= '0;
    end else begin
      resp_vld <= |grant;
      if (|grant) begin
        resp_owner <= grant_idx;
        rr_ptr     <= (grant_idx == IDX_W'(NUM_RD - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign rd_resp_valid = resp_vld ? (NUM_RD'(1) << resp_owner) : '0;
  assign rd_resp_data  = lsu_read_data;

`ifdef LSU_ARB_STATS_EN
  logic [NUM_RD-1:0][STAT_WIDTH-1:0] gcnt;
  logic [STAT_WIDTH-1:0]             hcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt <= '0;
      hcnt <= '0;
    end else if (stats_clr) begin
      gcnt <= '0;
      hcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        if (grant[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 1'b1;
      if (hazard && hcnt != '1) hcnt <= hcnt + 1'b1;
    end
  end

  assign grant_count  = gcnt;
  assign hazard_count = hcnt;
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed + random bench for lsu_arbiter against a cycle-level reference model.
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rd_req_valid = '0;
  logic [N*AW-1:0] rd_req_addr  = '0;
  logic [N-1:0]    rd_req_ready, rd_resp_valid;
  logic [DW-1:0]   rd_resp_data;
  logic            wr_valid = 1'b0;
  logic [AW-1:0]   wr_addr  = '0;
  logic [DW-1:0]   wr_data  = '0;
  logic            wr_ready, lsu_read_enable, lsu_write_enable;
  logic [AW-1:0]   lsu_read_ptr, lsu_write_ptr;
  logic [DW-1:0]   lsu_read_data = '0;
  logic [DW-1:0]   lsu_write_data;
`ifdef LSU_ARB_STATS_EN
  logic                    stats_clr = 1'b0;
  logic [N*STAT_WIDTH-1:0] grant_count;
  logic [STAT_WIDTH-1:0]   hazard_count;
`endif

  lsu_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(N)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .lsu_read_enable(lsu_read_enable), .lsu_read_ptr(lsu_read_ptr), .lsu_read_data(lsu_read_data),
    .lsu_write_enable(lsu_write_enable), .lsu_write_ptr(lsu_write_ptr), .lsu_write_data(lsu_write_data)
`ifdef LSU_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_count(grant_count), .hazard_count(hazard_count)
`endif
  );

  // LSU line buffer: registered read, read-before-write on collision.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (lsu_write_enable) mem[lsu_write_ptr] <= lsu_write_data;
    if (lsu_read_enable)  lsu_read_data <= mem[lsu_read_ptr];
  end

  int total = 0, bad = 0;
  int rr = 0, exp_g = -1, last_g = -1;
  bit hz = 0;
  logic [N-1:0]  exp_resp = '0;
  logic [DW-1:0] exp_data = '0;
  int gcnt [N];
  int hcnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return rd_req_addr[i*AW +: AW];
  endfunction

  task automatic set_rd(input int i, input logic v, input logic [AW-1:0] a);
    rd_req_valid[i] = v;
    rd_req_addr[i*AW +: AW] = a;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic model_reset();
    rr = 0; exp_resp = '0; last_g = -1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    hcnt = 0;
  endtask

  // One clock: check at negedge against the model, advance the model at posedge.
  task automatic step();
    @(negedge clk);
    exp_g = -1;
    hz = 0;
    if (!rst)
      for (int k = 0; k < N; k++)
        if (exp_g < 0 && rd_req_valid[(rr + k) % N]) exp_g = (rr + k) % N;
    if (exp_g >= 0 && wr_valid && addr_of(exp_g) == wr_addr) begin
      hz = 1;
      exp_g = -1;
    end
    chk("ready", DW'(rd_req_ready), (exp_g >= 0) ? DW'(1) << exp_g : '0);
    chk("rd_en", DW'(lsu_read_enable), DW'(exp_g >= 0));
    if (exp_g >= 0) chk("rd_ptr", DW'(lsu_read_ptr), DW'(addr_of(exp_g)));
    chk("wr_ready", DW'(wr_ready), DW'(!rst));
    chk("wr_en", DW'(lsu_write_enable), DW'(wr_valid && !rst));
    chk("wr_ptr", DW'(lsu_write_ptr), DW'(wr_addr));
    chk("wr_data", lsu_write_data, wr_data);
    chk("resp_valid", DW'(rd_resp_valid), rst ? '0 : DW'(exp_resp));
    if (!rst && exp_resp != '0) chk("resp_data", rd_resp_data, exp_data);
`ifdef LSU_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("grant_count", DW'(grant_count[i*STAT_WIDTH +: STAT_WIDTH]), DW'(gcnt[i]));
    chk("hazard_count", DW'(hazard_count), DW'(hcnt));
`endif
    @(posedge clk);
    if (rst) model_reset();
    else begin
`ifdef LSU_ARB_STATS_EN
      if (stats_clr) begin
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        hcnt = 0;
      end else begin
        if (exp_g >= 0 && gcnt[exp_g] < 16'hFFFF) gcnt[exp_g]++;
        if (hz && hcnt < 16'hFFFF) hcnt++;
      end
`endif
      if (exp_g >= 0) begin
        exp_resp = N'(1) << exp_g;
        exp_data = ref_mem[addr_of(exp_g)];
        rr = (exp_g + 1) % N;
      end else exp_resp = '0;
      if (wr_valid) ref_mem[wr_addr] = wr_data;
      last_g = exp_g;
    end
    #1;
  endtask

  task automatic clear_inputs();
    rd_req_valid = '0; rd_req_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [DW-1:0] old31;
  bit            rv [N];
  logic [AW-1:0] ra [N];

  initial begin
    for (int a = 0; a < (1 << AW); a++) poke(AW'(a), {4{32'(a) ^ 32'hC0DE_0000}});
    model_reset();

    // reset state
    step();
    step();
    rst = 1'b0;

    // single reader
    poke(14'h0010, {16{8'hA5}});
    set_rd(0, 1'b1, 14'h0010);
    step();
    set_rd(0, 1'b0, '0);
    chk("t1_resp_valid", DW'(rd_resp_valid), DW'(3'b001));
    chk("t1_resp_data", rd_resp_data, {16{8'hA5}});
    step();

    // all requesters continuously valid: strict rotation, no idle cycles
    do_reset();
    for (int i = 0; i < N; i++) set_rd(i, 1'b1, AW'(14'h0100 + i));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_rotation", DW'(rd_resp_valid), DW'(N'(1) << (k % N)));
    end

    // same-address hazard
    do_reset();
    set_rd(1, 1'b1, 14'h0020);
    wr_valid = 1'b1; wr_addr = 14'h0020; wr_data = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FFEF;
    step();
    chk("t3_stall", DW'(rd_resp_valid), '0);
    wr_valid = 1'b0;
    step();
    set_rd(1, 1'b0, '0);
    chk("t3_resp_valid", DW'(rd_resp_valid), DW'(3'b010));
    chk("t3_resp_data", rd_resp_data, 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FFEF);
`ifdef LSU_ARB_STATS_EN
    chk("t3_hazard_count", DW'(hazard_count), DW'(1));
`endif
    step();

    // neighbouring addresses: read and write proceed together
    do_reset();
    old31 = ref_mem[14'h0031];
    set_rd(0, 1'b1, 14'h0031);
    wr_valid = 1'b1; wr_addr = 14'h0030; wr_data = {8{16'hBEEF}};
    step();
    clear_inputs();
    chk("t4_resp_valid", DW'(rd_resp_valid), DW'(3'b001));
    chk("t4_resp_data", rd_resp_data, old31);
    step();

    // reset with a response in flight
    do_reset();
    set_rd(2, 1'b1, 14'h0040);
    step();
    chk("t5_pre_valid", DW'(rd_resp_valid), DW'(3'b100));
    rst = 1'b1;
    #1;
    chk("t5_async_drop", DW'(rd_resp_valid), '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_rd(i, 1'b1, AW'(14'h0050 + i));
    step();
    chk("t5_first_winner", DW'(rd_resp_valid), DW'(3'b001));

    // random traffic honouring the hold-until-ready contract
    do_reset();
    for (int i = 0; i < N; i++) rv[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] || last_g == i) begin
          rv[i] = ($urandom_range(0, 3) != 0);
          ra[i] = AW'($urandom_range(0, 7));
        end
      for (int i = 0; i < N; i++) set_rd(i, rv[i], ra[i]);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

`ifdef LSU_ARB_STATS_EN
    // counter saturation and synchronous clear
    do_reset();
    set_rd(0, 1'b1, 14'h0060);
    for (int c = 0; c < 70000; c++) step();
    chk("stats_saturated", DW'(grant_count[STAT_WIDTH-1:0]), DW'(16'hFFFF));
    clear_inputs();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_cleared", DW'(grant_count[STAT_WIDTH-1:0]), '0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
